// File: rtl/dump_sustain_ctrl.sv
// dump_sustain_ctrl
//   Initiator side of the dump-sustain timer handshake. A go request raises
//   state_start and waits for the timer's start pulse. The dump switch is then
//   held for DUMP_CYCLES, a guard gap of GAP_CYCLES follows, and done pulses.
//   A watchdog returns to idle with timeout_err if start never arrives.
// Ports:
//   clk_5k, rst          : 5 kHz sequencer clock, synchronous active-high reset
//   go, abort, start     : sequence request, cancel, timer expiry pulse
//   state_start, dump_on : timer request level, dump switch drive
//   busy, done           : not-idle flag, one-cycle completion pulse
//   timeout_err          : one-cycle watchdog expiry pulse
// All outputs are registered and decoded from the next state, so each output
// appears on the edge where its state is entered.

module dump_sustain_ctrl #(
  parameter int unsigned DUMP_CYCLES    = 10,   // 1..255
  parameter int unsigned GAP_CYCLES     = 2,    // 0..255, 0 skips the gap
  parameter int unsigned TIMEOUT_CYCLES = 1000  // 2..65535
) (
  input  logic clk_5k,
  input  logic rst,
  input  logic go,
  input  logic abort,
  input  logic start,
  output logic state_start,
  output logic dump_on,
  output logic busy,
  output logic done,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_TMR = 3'd1,
    S_DUMP     = 3'd2,
    S_GAP      = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  // Terminal counts; the counter reads 0 on the first cycle of a state.
  localparam logic [15:0] DUMP_LAST = 16'(DUMP_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam bit          GAP_SKIP  = (GAP_CYCLES == 0);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        state_start_q, state_start_d;
  logic        dump_on_q, dump_on_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_err_q, timeout_err_d;

  // Next-state logic. abort takes priority over every other input.
  always_comb begin
    state_d       = state_q;
    timeout_err_d = 1'b0;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go && !abort) state_d = S_WAIT_TMR;
        end
        S_WAIT_TMR: begin
          // start on the expiry cycle wins over the watchdog
          if (start) begin
            state_d = S_DUMP;
          end else if (cnt_q == TO_LAST) begin
            state_d       = S_IDLE;
            timeout_err_d = 1'b1;
          end
        end
        S_DUMP: begin
          if (cnt_q == DUMP_LAST) state_d = GAP_SKIP ? S_DONE : S_GAP;
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Shared watchdog/phase counter: clears on any state entry, saturates
  // rather than wrapping so a stale compare can never re-fire.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      cnt_d = 16'd0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Output decode from the next state.
  always_comb begin
    state_start_d = (state_d == S_WAIT_TMR) || (state_d == S_DUMP) ||
                    (state_d == S_GAP);
    dump_on_d     = (state_d == S_DUMP);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clk_5k) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'd0;
      state_start_q <= 1'b0;
      dump_on_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      state_start_q <= state_start_d;
      dump_on_q     <= dump_on_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign state_start = state_start_q;
  assign dump_on     = dump_on_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule
